// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared definitions for the memory bus controller: FSM state
//               encoding, transfer kinds, d_size encodings and the width of
//               the access wait counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Bus controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Kind of the transfer currently owning the bus
    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_READ  = 2'd1,
        KIND_WRITE = 2'd2
    } kind_t;

    // d_size encodings
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Wait counter width; holds WAIT_CYC values 0..15
    localparam int WCNT_W = 4;

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_bus_ctrl_byte_lane_mux.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_mux
// Description : Combinational byte-lane steering. Read path selects one lane
//               of the memory bus for byte accesses and sign/zero extends it;
//               write path replicates the low data byte onto every lane.
// Ports       : lane      - byte lane index (address LSBs)
//               rd_size   - size of the read being completed
//               sext      - sign-extend a byte read when high
//               bus_rdata - raw memory read data
//               rd_data   - steered/extended read result
//               wr_size   - size of the write being issued
//               wdata     - requester write data
//               bus_wdata - data to drive on the memory bus
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_mux
    import mem_bus_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [$clog2(DW/8)-1:0] lane,
    input  logic                    rd_size,
    input  logic                    sext,
    input  logic [DW-1:0]           bus_rdata,
    output logic [DW-1:0]           rd_data,
    input  logic                    wr_size,
    input  logic [DW-1:0]           wdata,
    output logic [DW-1:0]           bus_wdata
);

    localparam int LANES = DW / 8;

    logic [7:0] w_byte;

    always_comb begin
        // lane * 8 formed by concatenation so the index stays a plain vector
        w_byte = bus_rdata[{lane, 3'b000} +: 8];

        if (rd_size == SIZE_WORD) begin
            rd_data = bus_rdata;
        end else begin
            rd_data = {{(DW - 8){sext & w_byte[7]}}, w_byte};
        end

        if (wr_size == SIZE_WORD) begin
            bus_wdata = wdata;
        end else begin
            bus_wdata = {LANES{wdata[7:0]}};
        end
    end

endmodule : byte_lane_mux
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Two-requester memory bus controller. Arbitrates an
//               instruction-fetch port and a data port (data wins) onto a
//               single asynchronous-style memory bus with SETUP / ACCESS /
//               DONE phases, programmable minimum wait states and mem_rdy
//               stretching. Misaligned word data accesses are rejected.
// Ports       : clk, rst              - clock, async active-high reset
//               if_req/if_addr        - fetch request and word address
//               if_rdata/if_done      - fetched word and completion pulse
//               d_rd_req/d_wr_req     - data read / write requests
//               d_addr/d_size/d_sext  - data address, size, sign-extend
//               d_wdata/d_rdata       - data write / read values
//               d_done/d_err          - completion / misalignment pulses
//               abus, dbus_in/out/oe  - memory address and data buses
//               mem_rdy               - memory ready (low extends access)
//               nmreq, nrd, nwr, nbe  - active-low memory strobes/enables
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int WAIT_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    input  logic            d_rd_req,
    input  logic            d_wr_req,
    input  logic [AW-1:0]   d_addr,
    input  logic            d_size,
    input  logic            d_sext,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            d_err,
    output logic [AW-1:0]   abus,
    input  logic [DW-1:0]   dbus_in,
    output logic [DW-1:0]   dbus_out,
    output logic            dbus_oe,
    input  logic            mem_rdy,
    output logic            nmreq,
    output logic            nrd,
    output logic            nwr,
    output logic [DW/8-1:0] nbe
);

    localparam int LANES = DW / 8;
    localparam int LSB   = $clog2(LANES);

    state_t              r_state;
    kind_t               r_kind;
    logic [AW-1:0]       r_addr;
    logic                r_size;
    logic                r_sext;
    logic [WCNT_W-1:0]   r_wcnt;

    logic                w_d_req;
    logic                w_d_misaligned;
    logic [LANES-1:0]    w_nbe_d;
    logic [DW-1:0]       w_rd_data;
    logic [DW-1:0]       w_wr_data;

    assign w_d_req        = d_rd_req | d_wr_req;
    assign w_d_misaligned = (d_size == SIZE_WORD) && (d_addr[LSB-1:0] != '0);
    assign w_nbe_d        = (d_size == SIZE_WORD) ? '0
                                                  : ~(LANES'(1) << d_addr[LSB-1:0]);
    assign abus           = r_addr;

    // Read path uses the latched access; write path uses the live request
    // because write data is registered onto the bus at grant.
    byte_lane_mux #(
        .DW (DW)
    ) u_lane_mux (
        .lane      (r_addr[LSB-1:0]),
        .rd_size   (r_size),
        .sext      (r_sext),
        .bus_rdata (dbus_in),
        .rd_data   (w_rd_data),
        .wr_size   (d_size),
        .wdata     (d_wdata),
        .bus_wdata (w_wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_kind   <= KIND_FETCH;
            r_addr   <= '0;
            r_size   <= SIZE_WORD;
            r_sext   <= 1'b0;
            r_wcnt   <= '0;
            nmreq    <= 1'b1;
            nrd      <= 1'b1;
            nwr      <= 1'b1;
            nbe      <= '1;
            dbus_oe  <= 1'b0;
            dbus_out <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // The cycle carrying an error pulse is skipped so a
                    // requester still holding its request while it sees
                    // d_err is not rejected a second time.
                    if (!d_err) begin
                        if (w_d_req) begin
                            if (w_d_misaligned) begin
                                d_err <= 1'b1;
                            end else begin
                                r_state <= ST_SETUP;
                                r_kind  <= d_wr_req ? KIND_WRITE : KIND_READ;
                                r_addr  <= d_addr;
                                r_size  <= d_size;
                                r_sext  <= d_sext;
                                nmreq   <= 1'b0;
                                nbe     <= w_nbe_d;
                                dbus_oe <= d_wr_req;
                                if (d_wr_req) begin
                                    dbus_out <= w_wr_data;
                                end
                            end
                        end else if (if_req) begin
                            r_state <= ST_SETUP;
                            r_kind  <= KIND_FETCH;
                            r_addr  <= if_addr;
                            r_size  <= SIZE_WORD;
                            r_sext  <= 1'b0;
                            nmreq   <= 1'b0;
                            nbe     <= '0;
                            dbus_oe <= 1'b0;
                        end
                    end
                end

                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    r_wcnt  <= WCNT_W'(WAIT_CYC);
                    if (r_kind == KIND_WRITE) begin
                        nwr <= 1'b0;
                    end else begin
                        nrd <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end else if (mem_rdy) begin
                        r_state <= ST_DONE;
                        nmreq   <= 1'b1;
                        nrd     <= 1'b1;
                        nwr     <= 1'b1;
                        nbe     <= '1;
                        dbus_oe <= 1'b0;
                        if (r_kind == KIND_FETCH) begin
                            if_rdata <= dbus_in;
                            if_done  <= 1'b1;
                        end else begin
                            if (r_kind == KIND_READ) begin
                                d_rdata <= w_rd_data;
                            end
                            d_done <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : mem_bus_ctrl
`default_nettype wire
